// File: rtl/npu_spi_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : npu_spi_cmd_parser_if
// Purpose  : Bundles the SPI byte-shifter, NPU buffer and NPU core signals
//            seen by the command parser. The parser uses the slave modport;
//            the surrounding system (shifter, buffer, core) uses master.
// Revision : 1.0 - initial release
// ============================================================================
interface npu_spi_cmd_parser_if #(
    parameter int ADDR_W = 10
);
    // Byte shifter side
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              frame_end;
    logic              tx_next;
    logic [7:0]        tx_byte;
    // NPU buffer side
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    // NPU core side
    logic              npu_start;
    logic              npu_done;
    logic              done;

    modport slave (
        input  rx_valid, rx_byte, frame_end, tx_next, mem_rdata, npu_done,
        output tx_byte, mem_we, mem_re, mem_addr, mem_wdata, npu_start, done
    );

    modport master (
        output rx_valid, rx_byte, frame_end, tx_next, mem_rdata, npu_done,
        input  tx_byte, mem_we, mem_re, mem_addr, mem_wdata, npu_start, done
    );
endinterface
`default_nettype wire

// File: rtl/npu_spi_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : npu_spi_cmd_parser
// Purpose  : Decodes SPI command frames (OP, ADDR_HI, ADDR_LO, LEN, data)
//            into NPU buffer writes/reads, core start pulses and status
//            reads, and supplies the next MISO byte to the shifter.
// Revision : 1.0 - initial release
// ============================================================================
module npu_spi_cmd_parser #(
    parameter int ADDR_W = 10
) (
    input  wire                    clk,
    input  wire                    rst_n,
    npu_spi_cmd_parser_if.slave    bus
);

    localparam logic [7:0] c_OP_WRITE  = 8'h01;
    localparam logic [7:0] c_OP_READ   = 8'h02;
    localparam logic [7:0] c_OP_START  = 8'h03;
    localparam logic [7:0] c_OP_STATUS = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_LEN     = 3'd3,
        S_WDATA   = 3'd4,
        S_RDATA   = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t            state_q,     state_d;
    logic              is_read_q,   is_read_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    // WRITE: bytes still to write. READ: fetches still to issue after the
    // one currently in flight or presented.
    logic [8:0]        cnt_q,       cnt_d;
    // mem_rdata carries data for the strobe issued last cycle
    logic              rd_pend_q,   rd_pend_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic [7:0]        tx_byte_q,   tx_byte_d;
    logic              mem_we_q,    mem_we_d;
    logic              mem_re_q,    mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              npu_start_q, npu_start_d;

    logic [ADDR_W-1:0] ptr_inc;

    assign ptr_inc = ptr_q + 1'b1;

    // State and output registers; reset drops every strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_byte_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            npu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tx_byte_q   <= tx_byte_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            npu_start_q <= npu_start_d;
        end
    end

    // Frame decode, buffer strobes, MISO byte selection and status flags
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rd_pend_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        tx_byte_d   = tx_byte_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        npu_start_d = 1'b0;

        // Core completion; a START accepted in the same cycle overrides below
        if (bus.npu_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (bus.frame_end) begin
            // Frame end beats any byte arriving in the same cycle
            state_d   = S_IDLE;
            tx_byte_d = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_byte)
                            c_OP_WRITE: begin
                                is_read_d = 1'b0;
                                state_d   = S_ADDR_HI;
                            end
                            c_OP_READ: begin
                                is_read_d = 1'b1;
                                state_d   = S_ADDR_HI;
                            end
                            c_OP_START: begin
                                npu_start_d = 1'b1;
                                done_d      = 1'b0;
                                err_d       = 1'b0;
                                busy_d      = 1'b1;
                                state_d     = S_DRAIN;
                            end
                            c_OP_STATUS: begin
                                tx_byte_d = {5'b0, err_q, busy_q, done_q};
                                state_d   = S_DRAIN;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_ADDR_HI: begin
                    if (bus.rx_valid) begin
                        // High byte lands above bit 8; bits beyond ADDR_W drop out
                        ptr_d   = ADDR_W'({bus.rx_byte, 8'h00});
                        state_d = S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (bus.rx_valid) begin
                        ptr_d   = ptr_q | ADDR_W'(bus.rx_byte);
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.rx_valid) begin
                        if (is_read_q) begin
                            // First fetch goes out immediately
                            cnt_d      = {1'b0, bus.rx_byte};
                            mem_re_d   = 1'b1;
                            mem_addr_d = ptr_q;
                            state_d    = S_RDATA;
                        end else begin
                            cnt_d   = {1'b0, bus.rx_byte} + 9'd1;
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = bus.rx_byte;
                        ptr_d       = ptr_inc;
                        cnt_d       = cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_RDATA: begin
                    rd_pend_d = mem_re_q;
                    if (rd_pend_q) begin
                        tx_byte_d = bus.mem_rdata;
                    end
                    if (bus.tx_next) begin
                        if (cnt_q != 9'd0) begin
                            ptr_d      = ptr_inc;
                            cnt_d      = cnt_q - 9'd1;
                            mem_re_d   = 1'b1;
                            mem_addr_d = ptr_inc;
                        end else begin
                            tx_byte_d = 8'h00;
                        end
                    end
                end
                S_DRAIN: begin
                    // A status byte is no longer pending once the shifter took it
                    if (bus.tx_next) begin
                        tx_byte_d = 8'h00;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.npu_start = npu_start_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire
